// File: rtl/rba_pkg.sv
// Shared types and helpers for the round-robin register-bank write arbiter.
// Holds the FSM state enum, the write-counter width and the round-robin pick function.
package rba_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } rba_state_e;

  localparam int WR_COUNT_W = 16;
  localparam int MAX_REQ    = 8;

  // Searches last+1, last+2, ... modulo num_req and returns the first set request.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         last,
                                         input int                 num_req);
    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = 3'((int'(last) + k) % num_req);
      if (k <= num_req && !found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: winner index and a valid flag from req and last winner.
module rr_arbiter
  import rba_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [IDX_W-1:0]   pick_o,
  output logic               valid_o
);

  logic [MAX_REQ-1:0] req_ext;

  assign req_ext = MAX_REQ'(req_i);
  assign pick_o  = IDX_W'(rr_pick(req_ext, 3'(last_i), NUM_REQ));
  assign valid_o = |req_i;

endmodule

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write arbiter in front of a flip-flop register bank with one combinational read port.
// Optional RBA_WR_COUNT_EN adds a saturating 16-bit count of committed in-range writes.
module reg_bank_write_arbiter
  import rba_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      busy,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [DATA_W-1:0]         rd_data
`ifdef RBA_WR_COUNT_EN
  ,
  output logic [WR_COUNT_W-1:0]     wr_count
`endif
);

  rba_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [IDX_W-1:0]    pick;
  logic                pick_valid;
  logic                in_range;
  logic                commit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i   (req),
    .last_i  (last_q),
    .pick_o  (pick),
    .valid_o (pick_valid)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    state_d = state_q;
    gnt_d   = '0;
    win_d   = win_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d     = ST_GRANT;
          gnt_d[pick] = 1'b1;
          win_d       = pick;
          addr_d      = wr_addr[int'(pick)*ADDR_W +: ADDR_W];
          data_d      = wr_data[int'(pick)*DATA_W +: DATA_W];
        end
      end
      ST_GRANT: begin
        state_d = ST_IDLE;
        last_d  = win_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      win_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      win_q   <= win_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign in_range = (int'(addr_q) < DEPTH);
  assign commit   = (state_q == ST_GRANT) && in_range;

  // NOTE: this bank is flops, not RAM, and every entry must read 0 after reset, so each one is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (commit) begin
      mem_q[addr_q] <= data_q;
    end
  end

  assign rd_data = (int'(rd_addr) < DEPTH) ? mem_q[rd_addr] : '0;
  assign gnt     = gnt_q;
  assign busy    = (state_q == ST_GRANT);

`ifdef RBA_WR_COUNT_EN
  logic [WR_COUNT_W-1:0] wr_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count_q <= '0;
    end else if (commit && (wr_count_q != '1)) begin
      wr_count_q <= wr_count_q + 1'b1;
    end
  end

  assign wr_count = wr_count_q;
`endif

endmodule

// File: doc/reg_bank_write_arbiter.md
Name: reg_bank_write_arbiter

Overview:
Round-robin write arbiter for a small flip-flop register bank shared by NUM_REQ requesters. The arbiter sequences exclusive single-cycle write grants and commits the winning address and data into internal edge-triggered storage. It exposes one asynchronous (combinational) read port. It sits between requester logic and the shared register storage and is the only writer of that storage.

Parameters:
NUM_REQ, 4, number of write requesters (2..8)
DATA_W, 8, width of each register entry
DEPTH, 8, number of register entries (2..256); ADDR_W = $clog2(DEPTH) is a localparam

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester write request, level
wr_addr  input  NUM_REQ*ADDR_W  flattened per-requester address; requester i uses slice [i*ADDR_W +: ADDR_W]
wr_data  input  NUM_REQ*DATA_W  flattened per-requester data, same slicing
gnt  output  NUM_REQ  one-hot grant pulse, registered
busy  output  1  high while in GRANT state
rd_addr  input  ADDR_W  read address
rd_data  output  DATA_W  combinational read of storage[rd_addr]

Behaviour:
- Reset (rst_n low, asynchronous):
  - gnt=0, busy=0, FSM=IDLE.
  - Every storage entry = 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has top priority after reset.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If any req bit is high at a rising edge, select the winner: the first set bit searching last+1, last+2, … modulo NUM_REQ.
  - At that edge, latch the winner index, its wr_addr slice and its wr_data slice.
  - Set gnt[winner]=1 and busy=1, and go to GRANT.
  - If no req bit is high, stay in IDLE with gnt=0.
- GRANT (always exactly one cycle):
  - At the closing edge, write storage[latched addr] <= latched data.
  - Set last = winner, clear gnt and busy, and return to IDLE.
- Throughput is one write per 2 cycles. Latency from req sampled to storage updated is 2 edges.
- Requester protocol:
  - Hold req, wr_addr and wr_data stable until gnt is seen.
  - Deassert req in the cycle gnt is high unless a further write is wanted.
  - A req still high in IDLE after the grant is treated as a new request.
- Req dropped during GRANT: the write still commits, because address and data were latched at grant.
- Req, address and data changes during GRANT have no effect on the current write.
- Read port:
  - rd_data is purely combinational from storage.
  - A read of the address being written in the GRANT cycle returns the old value until the commit edge, then the new value.
- Out-of-range address (DEPTH not a power of two):
  - A write with wr_addr >= DEPTH is dropped; gnt still pulses and the pointer still advances.
  - rd_addr >= DEPTH returns 0.
- Fairness: any continuously asserted req is granted within NUM_REQ grants.
- Reset asserted mid-GRANT: the write is aborted and all reset values are applied immediately. There is no partial write.
- gnt is never multi-hot; at most one gnt pulse every 2 cycles.

Optional Feature:
Macro RBA_WR_COUNT_EN.
- Defined:
  - Adds output port wr_count (16 bits).
  - wr_count increments by 1 on every committed in-range write and saturates at 16'hFFFF.
  - Reset value is 0; out-of-range dropped writes are not counted.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package rba_pkg holds:
  - FSM state enum (IDLE, GRANT)
  - the wr_count width constant (16)
  - a function rr_pick(req, last) returning the winner index
- One natural sub-module: rr_arbiter (combinational round-robin pick from req and last, plus valid flag). Storage and FSM stay in the top.

Test Plan:
- Reset with all inputs 0 -> gnt=0, busy=0, every rd_addr reads 0; async assert mid-cycle clears outputs without a clock edge.
- Single request: req=4'b0100, addr=3, data=8'hA5 -> gnt=4'b0100 for exactly one cycle, 2 edges after sample; rd_addr=3 then reads 8'hA5.
- All four req held high -> grant order 0,1,2,3,0, gnt never multi-hot, one pulse every 2 cycles.
- req[1] writes addr 5 = 8'h3C, then req[3] writes addr 5 = 8'hC3 -> final rd_data=8'hC3; rd_addr=5 during the second GRANT cycle still shows 8'h3C.
- rst_n pulsed low during GRANT with data 8'hFF to addr 2 -> addr 2 reads 0, pointer resets, next grant goes to the lowest-index active req.
- DEPTH=6, write addr 7 -> gnt pulses, storage unchanged; with RBA_WR_COUNT_EN, 3 valid writes -> wr_count=3, and a preload near saturation holds at 16'hFFFF.
